// File: rtl/inst_fetch.sv
// inst_fetch: four-state fetch/decode/execute sequencer with PC, instruction register and sticky fetch timeout
module inst_fetch (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_run,
  input  logic [15:0] I_mem_data,
  input  logic        I_mem_ack,
  input  logic        I_exec_done,
  input  logic        I_branch,
  input  logic [15:0] I_target,
  output logic        O_mem_req,
  output logic [15:0] O_mem_addr,
  output logic [15:0] O_inst,
  output logic        O_dec_en,
  output logic [15:0] O_pc,
  output logic        O_fault,
  output logic        O_busy
);
  typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;
  state_t      state;
  logic [15:0] pc;
  logic [3:0]  tmo;
  assign O_pc       = pc;
  assign O_mem_addr = pc;
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      O_inst    <= '0;
      O_mem_req <= 1'b0;
      O_dec_en  <= 1'b0;
      O_fault   <= 1'b0;
      O_busy    <= 1'b0;
      tmo       <= '0;
    end else
      case (state)
        IDLE:
          if (I_run) begin
            state     <= FETCH;
            O_mem_req <= 1'b1;
            O_busy    <= 1'b1;
            O_fault   <= 1'b0;
            tmo       <= '0;
          end
        FETCH:
          if (I_mem_ack) begin
            O_inst    <= I_mem_data;
            pc        <= pc + 16'd1;
            O_mem_req <= 1'b0;
            O_dec_en  <= 1'b1;
            tmo       <= '0;
            state     <= DECODE;
          end else if (tmo == 4'hf) begin
            O_fault   <= 1'b1;
            O_mem_req <= 1'b0;
            O_busy    <= 1'b0;
            state     <= IDLE;
          end else
            tmo <= tmo + 4'd1;
        DECODE: begin
          O_dec_en <= 1'b0;
          state    <= EXEC;
        end
        EXEC:
          if (I_exec_done) begin
            pc        <= I_branch ? I_target : pc;
            state     <= I_run ? FETCH : IDLE;
            O_mem_req <= I_run;
            O_busy    <= I_run;
            tmo       <= '0;
          end
        default: state <= IDLE;
      endcase
endmodule
